// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: types and constants shared across the 6502 core.
package cpu6502_pkg;
    typedef enum logic {PC_IDLE, PC_CARRY} pc_state_t;
    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
endpackage

// File: rtl/byte_incrementer.sv
// byte_incrementer: 8-bit value plus a 1-bit carry-in, producing sum and carry-out.
module byte_incrementer (
    input  logic [7:0] i_data,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_data} + {8'd0, i_cin};
endmodule

// File: rtl/pc_increment_unit.sv
// pc_increment_unit: PCL/PCH registers with increment and registered (or fast) page carry.
module pc_increment_unit
    import cpu6502_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = RESET_VECTOR,
    parameter bit          FAST_CARRY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic [7:0]  pcls,
    input  logic [7:0]  pchs,
    input  logic        load_pcl,
    input  logic        load_pch,
    input  logic        incr,
    output logic [7:0]  pcl,
    output logic [7:0]  pch,
    output logic [15:0] addr,
    output logic        carry_pending,
    output logic        page_cross,
    output logic        pc_wrap
);
    pc_state_t   r_state, w_state_nxt;
    logic [7:0]  r_pcl, r_pch, w_lsrc, w_hsrc, w_lsum, w_hsum;
    logic        r_carry_q, r_page_cross, r_pc_wrap, w_cout, w_hcout, w_hadd;

    assign w_lsrc = load_pcl ? pcls : r_pcl;
    assign w_hsrc = load_pch ? pchs : r_pch;
    // Slow mode applies last cycle's PCL carry; fast mode chains it combinationally.
    assign w_hadd = FAST_CARRY ? w_cout : r_carry_q;

    byte_incrementer u_lo (.i_data(w_lsrc), .i_cin(incr),   .o_sum(w_lsum), .o_cout(w_cout));
    byte_incrementer u_hi (.i_data(w_hsrc), .i_cin(w_hadd), .o_sum(w_hsum), .o_cout(w_hcout));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= PC_IDLE;
            r_carry_q    <= 1'b0;
            {r_pch, r_pcl} <= RESET_PC;
        end else if (rdy) begin
            r_state   <= w_state_nxt;
            r_carry_q <= !FAST_CARRY && w_cout;
            r_pcl     <= w_lsum;
            r_pch     <= w_hsum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_page_cross <= 1'b0;
            r_pc_wrap    <= 1'b0;
        end else begin
            r_page_cross <= w_cout & rdy;
            r_pc_wrap    <= w_hcout & rdy;
        end
    end

    always_comb begin
        w_state_nxt = PC_IDLE;
        if (!FAST_CARRY && w_cout) w_state_nxt = PC_CARRY;
    end

    always_comb begin
        carry_pending = r_state == PC_CARRY;
        pcl           = r_pcl;
        pch           = r_pch;
        addr          = {r_pch, r_pcl};
        page_cross    = r_page_cross;
        pc_wrap       = r_pc_wrap;
    end
endmodule
